// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: ALU opcodes, MDU state encoding and default width shared with the ALU control decoder
package mult_div_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_MFHI = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_MFLO = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1110;
    localparam logic [3:0] ALU_DIV  = 4'b1111;

    typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;

    function automatic logic is_md_op(input logic [3:0] op);
        return op == ALU_MULT || op == ALU_DIV;
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: conditional two's-complement negate, used both for operand magnitudes and result sign correction
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed mult/div over operand magnitudes with HI/LO registers and pipeline stall
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_result
);

    md_state_t        state, next_state;
    logic             op_div, sign_a, sign_b, accept;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mag_b, a_raw, acc, quo;
    logic [WIDTH-1:0] abs_a, abs_b, quo_fix, rem_fix;
    logic [WIDTH:0]   add_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept    = state == IDLE && start && is_md_op(alu_ctrl);
    assign busy      = state != IDLE;
    assign stall     = busy || (start && is_md_op(alu_ctrl));
    assign mf_result = alu_ctrl == ALU_MFHI ? hi : alu_ctrl == ALU_MFLO ? lo : '0;

    // acc:quo acts as product shift register for mult and as remainder:dividend/quotient for div
    assign add_sum   = {1'b0, acc} + (quo[0] ? {1'b0, mag_b} : '0);
    assign div_shift = {acc, quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};

    md_sign_fix #(.W(WIDTH)) u_abs_a (.val(op_a), .neg(op_a[WIDTH-1]), .res(abs_a));
    md_sign_fix #(.W(WIDTH)) u_abs_b (.val(op_b), .neg(op_b[WIDTH-1]), .res(abs_b));
    md_sign_fix #(.W(2*WIDTH)) u_prod (.val({acc, quo}), .neg(sign_a ^ sign_b), .res(prod_fix));
    md_sign_fix #(.W(WIDTH)) u_quo (.val(quo), .neg(sign_a ^ sign_b), .res(quo_fix));
    md_sign_fix #(.W(WIDTH)) u_rem (.val(acc), .neg(sign_a), .res(rem_fix));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // next-state: IDLE -> CALC for WIDTH cycles -> FIX -> IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? CALC : IDLE;
            CALC:    next_state = cnt == '0 ? FIX : CALC;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // operand capture, one shift-add / restoring step per CALC cycle, HI/LO write in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_div      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            mag_b       <= '0;
            a_raw       <= '0;
            acc         <= '0;
            quo         <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= state == FIX;
            div_by_zero <= state == FIX && op_div && mag_b == '0;
            if (accept) begin
                op_div <= alu_ctrl == ALU_DIV;
                sign_a <= op_a[WIDTH-1];
                sign_b <= op_b[WIDTH-1];
                mag_b  <= abs_b;
                a_raw  <= op_a;
                acc    <= '0;
                quo    <= abs_a;
                cnt    <= CNT_W'(WIDTH - 1);
            end else if (state == CALC) begin
                cnt <= cnt - 1'b1;
                if (op_div) begin
                    acc <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc <= add_sum[WIDTH:1];
                    quo <= {add_sum[0], quo[WIDTH-1:1]};
                end
            end else if (state == FIX) begin
                if (!op_div) begin
                    {hi, lo} <= prod_fix;
                end else if (mag_b == '0) begin
                    hi <= a_raw;
                    lo <= '1;
                end else begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult/div results, latency, div-by-zero, stall and async reset
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a, op_b;
    logic        busy, done, div_by_zero, stall;
    logic [31:0] hi, lo, mf_result;

    int n_vec = 0;
    int n_err = 0;

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .stall(stall), .hi(hi), .lo(lo),
        .mf_result(mf_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drive one start cycle (cycle N), return at the negedge of cycle N+1
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; alu_ctrl = op; op_a = a; op_b = b;
        #1 check("stall_on_start", stall, 1);
        @(negedge clk);
        start = 1'b0; alu_ctrl = ALU_ADD;
    endtask

    // from cycle c0 after N, wait for done; report the cycle index, busy cycles and div_by_zero pulses seen
    task automatic wait_done(input int c0, output int cyc, output int bcnt, output int zcnt);
        cyc = c0; bcnt = 0; zcnt = 0;
        while (!done && cyc < 80) begin
            bcnt += int'(busy);
            zcnt += int'(div_by_zero);
            @(negedge clk);
            cyc++;
        end
        zcnt += int'(div_by_zero);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_z);
        int cyc, bcnt, zcnt;
        launch(op, a, b);
        wait_done(1, cyc, bcnt, zcnt);
        check({tag, "_latency"}, cyc, 34);
        check({tag, "_busy_cycles"}, bcnt, 33);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_dbz"}, zcnt, exp_z);
        @(negedge clk);
        check({tag, "_done_pulse"}, {done, div_by_zero}, 0);
    endtask

    initial begin
        int cyc, bcnt, zcnt, seen;
        rst_n = 1'b0; start = 1'b0; alu_ctrl = ALU_ADD; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_hilo", {hi, lo}, 0);
        check("rst_flags", {busy, done, div_by_zero, stall}, 0);
        rst_n = 1'b1;

        run_op("mul_7_m3", ALU_MULT, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("mul_min_min", ALU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
        run_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_min_m1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
        run_op("div_100_0", ALU_DIV, 32'd100, 32'h0, 32'h64, 32'hFFFF_FFFF, 1);
        alu_ctrl = ALU_MFHI;
        #1 check("mfhi_after_dbz", mf_result, 32'h64);
        alu_ctrl = ALU_ADD;

        launch(ALU_MULT, 32'd3, 32'hFFFF_FFFC);
        @(negedge clk);
        alu_ctrl = ALU_MFHI;
        #1 check("stall_mfhi_busy", stall, 1);
        start = 1'b1; alu_ctrl = ALU_MULT; op_a = 32'd2; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0; alu_ctrl = ALU_ADD;
        wait_done(3, cyc, bcnt, zcnt);
        check("busy_ignore_latency", cyc, 34);
        check("busy_ignore_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);
        alu_ctrl = ALU_MFLO;
        #1 check("mflo_result", mf_result, 32'hFFFF_FFF4);
        check("mflo_stall", stall, 0);
        alu_ctrl = ALU_MFHI;
        #1 check("mfhi_result", mf_result, 32'hFFFF_FFFF);
        alu_ctrl = ALU_ADD;
        #1 check("mf_other_zero", mf_result, 0);

        launch(ALU_MULT, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1 check("midop_rst_hilo", {hi, lo}, 0);
        check("midop_rst_flags", {busy, done, div_by_zero}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen += int'(done);
        end
        check("midop_no_done", seen, 0);
        run_op("mul_5_5", ALU_MULT, 32'd5, 32'd5, 32'h0, 32'h19, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
